// File: rtl/tick_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tick_div_pkg                                               |
// | Description : Shared constants, per-channel state record and divisor     |
// |               helper for the tick_divider block.                         |
// |               No ports (package).                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tick_div_pkg;

   // Default configuration of the top level.
   localparam int          NUM_CH_DEF   = 4;
   localparam int          NUM_CH_MAX   = 16;
   localparam int          DIV_W_DEF    = 32;
   localparam int unsigned DIV_INIT_DEF = 25000;

   // Channel state is held at a fixed storage width so that a single struct
   // type serves every DIV_W up to this limit. Narrower divisors are
   // zero-extended on entry, so the upper bits stay constant zero.
   localparam int DIV_W_MAX = 64;

   typedef struct packed {
      logic [DIV_W_MAX-1:0] cnt;   // position within the current period
      logic [DIV_W_MAX-1:0] div;   // divisor in force
      logic [DIV_W_MAX-1:0] pdiv;  // divisor waiting to take effect
      logic                 pend;  // pdiv is waiting to take effect
   } chan_state_t;

   // A divisor of zero behaves exactly like a divisor of one.
   function automatic logic [DIV_W_MAX-1:0] eff_div(input logic [DIV_W_MAX-1:0] d);
      return (d == '0) ? DIV_W_MAX'(1) : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_div_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tick_div_chan                                              |
// | Description : One divider channel: counter, active/pending divisor,      |
// |               registered one-cycle tick and 50 % square wave.            |
// | Ports       : clk, rst     - clock, synchronous active-high reset        |
// |               i_en         - count enable                                |
// |               i_step       - step condition (always 1 unless cascaded)   |
// |               i_sync       - realign phase, apply pending divisor        |
// |               i_load       - accepted divisor load for this channel      |
// |               i_load_div   - divisor value of the load                   |
// |               o_pend       - a divisor is pending                        |
// |               o_tick       - one-cycle strobe after each wrap            |
// |               o_sq         - toggles together with o_tick                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tick_div_chan
   import tick_div_pkg::*;
#(
   parameter int          DIV_W    = DIV_W_DEF,
   parameter int unsigned DIV_INIT = DIV_INIT_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_step,
   input  logic             i_sync,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_load_div,
   output logic             o_pend,
   output logic             o_tick,
   output logic             o_sq
);

   localparam logic [DIV_W_MAX-1:0] c_div_rst = DIV_W_MAX'(DIV_W'(DIV_INIT));

   chan_state_t          r_st;
   logic                 r_tick;
   logic                 r_sq;

   logic                 w_adv;
   logic                 w_wrap;
   logic                 w_apply;
   logic [DIV_W_MAX-1:0] w_div_eff;

   always_comb begin
      w_div_eff = eff_div(r_st.div);
      w_adv     = i_en & i_step;
      // ">=" rather than "==": a smaller divisor applied while the channel
      // sat disabled may leave cnt beyond the new last count; it then wraps
      // on the next advance instead of running round the whole counter.
      w_wrap    = w_adv & (r_st.cnt >= (w_div_eff - DIV_W_MAX'(1)));
      // A pending divisor only lands on a period boundary, when the channel
      // is idle, or on a realign, so a running period is never cut short.
      w_apply   = r_st.pend & (i_sync | ~i_en | w_wrap);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st.cnt  <= '0;
         r_st.div  <= c_div_rst;
         r_st.pdiv <= '0;
         r_st.pend <= 1'b0;
         r_tick    <= 1'b0;
         r_sq      <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (i_sync) begin
            r_st.cnt <= '0;
            r_sq     <= 1'b0;
         end else if (w_adv) begin
            r_st.cnt <= w_wrap ? '0 : (r_st.cnt + DIV_W_MAX'(1));
            r_tick   <= w_wrap;
            r_sq     <= r_sq ^ w_wrap;
         end
         if (w_apply) begin
            r_st.div  <= r_st.pdiv;
            r_st.pend <= 1'b0;
         end
         // Loads are only accepted while nothing is pending, so this never
         // collides with w_apply; a load landing on a wrap waits a period.
         if (i_load) begin
            r_st.pdiv <= DIV_W_MAX'(i_load_div);
            r_st.pend <= 1'b1;
         end
      end
   end

   assign o_pend = r_st.pend;
   assign o_tick = r_tick;
   assign o_sq   = r_sq;

endmodule
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tick_divider                                               |
// | Description : NUM_CH programmable tick dividers with divisor load        |
// |               handshake and common phase realign.                        |
// | Ports       : clk_50Mhz  - 50 MHz clock                                  |
// |               rst        - synchronous active-high reset                 |
// |               en         - per-channel count enable                      |
// |               sync       - realign all channels                          |
// |               load_valid - divisor load request                          |
// |               load_ch    - channel addressed by the load                 |
// |               load_div   - new divisor value (0 behaves as 1)            |
// |               load_ready - addressed channel can take a load             |
// |               tick       - one-cycle strobe per channel period           |
// |               sq_out     - per-channel square wave                       |
// | Options     : TICK_DIVIDER_CASCADE_EN - channel i>0 advances on          |
// |               tick[i-1] instead of every clock cycle.                    |
// | Limits      : DIV_W <= 64, NUM_CH 1..16.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tick_divider
   import tick_div_pkg::*;
#(
   parameter int          NUM_CH   = NUM_CH_DEF,
   parameter int          DIV_W    = DIV_W_DEF,
   parameter int unsigned DIV_INIT = DIV_INIT_DEF
)(
   input  logic                                       clk_50Mhz,
   input  logic                                       rst,
   input  logic [NUM_CH-1:0]                          en,
   input  logic                                       sync,
   input  logic                                       load_valid,
   input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] load_ch,
   input  logic [DIV_W-1:0]                           load_div,
   output logic                                       load_ready,
   output logic [NUM_CH-1:0]                          tick,
   output logic [NUM_CH-1:0]                          sq_out
);

   localparam int LD_W = $clog2((NUM_CH > 1) ? NUM_CH : 2);

   logic [NUM_CH-1:0] w_pend;
   logic [NUM_CH-1:0] w_step;
   logic [NUM_CH-1:0] w_tick;
   logic [NUM_CH-1:0] w_sq;
   logic [NUM_CH-1:0] w_load_hit;
   logic              w_load_ready;

   // Channel decode. An address beyond NUM_CH-1 (non power-of-two NUM_CH)
   // selects nothing and reads as not ready, so such a load is never taken.
   always_comb begin
      w_load_ready = 1'b0;
      w_load_hit   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (load_ch == LD_W'(i)) begin
            w_load_ready  = ~w_pend[i];
            w_load_hit[i] = 1'b1;
         end
      end
   end

   assign load_ready = w_load_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
`ifdef TICK_DIVIDER_CASCADE_EN
      // Each stage counts the previous stage's ticks; one registered tick
      // of latency is added per stage.
      if (i == 0) begin : g_first
         assign w_step[i] = 1'b1;
      end else begin : g_casc
         assign w_step[i] = w_tick[i-1];
      end
`else
      assign w_step[i] = 1'b1;
`endif

      tick_div_chan #(
         .DIV_W    (DIV_W),
         .DIV_INIT (DIV_INIT)
      ) u_chan (
         .clk        (clk_50Mhz),
         .rst        (rst),
         .i_en       (en[i]),
         .i_step     (w_step[i]),
         .i_sync     (sync),
         .i_load     (load_valid & w_load_ready & w_load_hit[i]),
         .i_load_div (load_div),
         .o_pend     (w_pend[i]),
         .o_tick     (w_tick[i]),
         .o_sq       (w_sq[i])
      );
   end

   assign tick   = w_tick;
   assign sq_out = w_sq;

endmodule
`default_nettype wire

// File: tb/tb_tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tick_divider                                            |
// | Description : Self-checking bench for tick_divider: directed scenarios   |
// |               plus randomized traffic against a behavioural model.       |
// |               Follows TICK_DIVIDER_CASCADE_EN when it is defined.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tick_divider;

   localparam int NUM_CH   = 4;
   localparam int DIV_W    = 8;
   localparam int DIV_INIT = 4;

   logic              clk_50Mhz = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] en = '0;
   logic              sync = 1'b0;
   logic              load_valid = 1'b0;
   logic [1:0]        load_ch = '0;
   logic [DIV_W-1:0]  load_div = '0;
   logic              load_ready;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq_out;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state, one entry per channel.
   int m_cnt  [NUM_CH];
   int m_div  [NUM_CH];
   int m_pdiv [NUM_CH];
   bit m_pend [NUM_CH];
   bit m_tick [NUM_CH];
   bit m_sq   [NUM_CH];

   always #10 clk_50Mhz = ~clk_50Mhz;

   tick_divider #(
      .NUM_CH   (NUM_CH),
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
   ) dut (
      .clk_50Mhz  (clk_50Mhz),
      .rst        (rst),
      .en         (en),
      .sync       (sync),
      .load_valid (load_valid),
      .load_ch    (load_ch),
      .load_div   (load_div),
      .load_ready (load_ready),
      .tick       (tick),
      .sq_out     (sq_out)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit old_tick [NUM_CH];
      old_tick = m_tick;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            m_cnt[i] = 0; m_div[i] = DIV_INIT; m_pdiv[i] = 0;
            m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
         end else begin
            int  period;
            bit  stepping, advance, wrapped, accepted;
            period   = (m_div[i] == 0) ? 1 : m_div[i];
            stepping = 1'b1;
`ifdef TICK_DIVIDER_CASCADE_EN
            if (i > 0) stepping = old_tick[i-1];
`endif
            advance  = en[i] && stepping;
            wrapped  = advance && (m_cnt[i] + 1 >= period);
            accepted = load_valid && (int'(load_ch) == i) && !m_pend[i];
            m_tick[i] = 0;
            if (sync) begin
               m_cnt[i] = 0;
               m_sq[i]  = 0;
            end else if (advance) begin
               m_cnt[i]  = wrapped ? 0 : m_cnt[i] + 1;
               m_tick[i] = wrapped;
               if (wrapped) m_sq[i] = !m_sq[i];
            end
            if (m_pend[i] && (sync || !en[i] || wrapped)) begin
               m_div[i]  = m_pdiv[i];
               m_pend[i] = 0;
            end
            if (accepted) begin
               m_pdiv[i] = int'(load_div);
               m_pend[i] = 1;
            end
         end
      end
   endtask

   // One clock: check the handshake before the edge, outputs after it.
   task automatic cycle();
      logic [NUM_CH-1:0] exp_tick, exp_sq;
      #1;
      check_value("load_ready", 32'(load_ready), 32'(!m_pend[load_ch]));
      @(posedge clk_50Mhz);
      model_step();
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         exp_tick[i] = m_tick[i];
         exp_sq[i]   = m_sq[i];
      end
      check_value("tick", 32'(tick), 32'(exp_tick));
      check_value("sq_out", 32'(sq_out), 32'(exp_sq));
   endtask

   task automatic do_reset();
      rst = 1'b1; en = '0; sync = 1'b0; load_valid = 1'b0; load_ch = '0;
      cycle();
      cycle();
   endtask

   initial begin
      int seen [$];
      int cnt_t;

      // Bring the DUT out of its unknown power-up state before checking.
      @(posedge clk_50Mhz);
      model_step();
      #1;

      // Reset state and first-tick timing, tick period, square wave.
      do_reset();
      check_value("rst_tick", 32'(tick), 32'h0);
      check_value("rst_sq", 32'(sq_out), 32'h0);
      check_value("rst_ready", 32'(load_ready), 32'h1);
      rst = 1'b0; en = '1;
      for (int k = 1; k <= 13; k++) begin
         cycle();
         if (tick[0]) seen.push_back(k + 1);
         if (k == 4) check_value("sq_rise", 32'(sq_out[0]), 32'h1);
         if (k == 8) check_value("sq_fall", 32'(sq_out[0]), 32'h0);
      end
      check_value("tick_count", 32'(seen.size()), 32'd3);
      check_value("tick_edge_a", 32'(seen[0]), 32'd5);
      check_value("tick_edge_b", 32'(seen[1]), 32'd9);
      check_value("tick_edge_c", 32'(seen[2]), 32'd13);

      // Mid-count load, held pending to the wrap; second load refused.
      do_reset();
      rst = 1'b0; en = '1;
      cycle();
      load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd2;
      cycle();
      check_value("pend_ready", 32'(load_ready), 32'h0);
      load_div = 8'd7;
      cycle();
      load_valid = 1'b0;
      cycle();
      check_value("applied_ready", 32'(load_ready), 32'h1);
      cnt_t = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         cnt_t += int'(tick[0]);
      end
      check_value("div2_ticks", 32'(cnt_t), 32'd4);

      // Disabled channel holds; resumes where it stopped.
      do_reset();
      rst = 1'b0; en = '1;
      cycle(); cycle();
      en = 4'b1110;
      cnt_t = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         cnt_t += int'(tick[0]);
      end
      check_value("hold_ticks", 32'(cnt_t), 32'd0);
      check_value("hold_sq", 32'(sq_out[0]), 32'h0);
      en = '1;
      cycle();
      check_value("resume_early", 32'(tick[0]), 32'h0);
      cycle();
      check_value("resume_tick", 32'(tick[0]), 32'h1);

      // Realign with cnt=3 and sq_out=1.
      do_reset();
      rst = 1'b0; en = '1;
      for (int k = 0; k < 7; k++) cycle();
      check_value("pre_sync_sq", 32'(sq_out[0]), 32'h1);
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      check_value("sync_tick", 32'(tick[0]), 32'h0);
      check_value("sync_sq", 32'(sq_out[0]), 32'h0);
      cnt_t = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         cnt_t += int'(tick[0]);
      end
      check_value("sync_quiet", 32'(cnt_t), 32'd0);
      cycle();
      check_value("sync_next_tick", 32'(tick[0]), 32'h1);

      // Reset with a load pending discards it.
      do_reset();
      rst = 1'b0; en = '1;
      cycle();
      load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd9;
      cycle();
      load_valid = 1'b0;
      cycle();
      check_value("pend_before_rst", 32'(load_ready), 32'h0);
      rst = 1'b1;
      cycle();
      check_value("rst_mid_tick", 32'(tick), 32'h0);
      check_value("rst_mid_sq", 32'(sq_out), 32'h0);
      check_value("rst_mid_ready", 32'(load_ready), 32'h1);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
      check_value("rst_mid_tick0", 32'(tick[0]), 32'h1);
      for (int k = 0; k < 8; k++) cycle();

      // Randomized traffic against the model.
      for (int c = 0; c < 800; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         sync       = ($urandom_range(0, 39) == 0);
         en         = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
         load_valid = ($urandom_range(0, 2) == 0);
         load_ch    = 2'($urandom);
         load_div   = DIV_W'($urandom_range(0, 6));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of independent divider channels (1..16).
REQ-002 The module SHALL have parameter DIV_W, default 32, giving the divisor and counter width.
REQ-003 The module SHALL have parameter DIV_INIT, default 25000, giving the divisor loaded into every channel at reset.
REQ-004 The module SHALL have port clk_50Mhz, input, 1 bit: the single clock, 50 MHz.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port en, input, NUM_CH bits: per-channel count enable.
REQ-007 The module SHALL have port sync, input, 1 bit: phase realign of all channels.
REQ-008 The module SHALL have port load_valid, input, 1 bit: divisor load request.
REQ-009 The module SHALL have port load_ch, input, clog2(NUM_CH) bits (minimum 1): target channel of the load.
REQ-010 The module SHALL have port load_div, input, DIV_W bits: new divisor value.
REQ-011 The module SHALL have port load_ready, output, 1 bit: load accepted when load_valid and load_ready are both high.
REQ-012 The module SHALL have port tick, output, NUM_CH bits: one-cycle strobe per channel period.
REQ-013 The module SHALL have port sq_out, output, NUM_CH bits: square wave that toggles on every tick.

Function
REQ-014 Each channel SHALL hold a counter cnt (DIV_W bits), an active divisor div, a pending divisor pdiv and a pending flag pend.
REQ-015 An advance event for channel i SHALL occur when en[i] is high and the channel's step condition (REQ-026) is true.
REQ-016 On an advance event, the counter SHALL go to 0 if cnt >= div-1, otherwise to cnt+1.
REQ-017 A divisor value of 0 SHALL be treated as 1.
REQ-018 tick[i] SHALL be registered: it is high for exactly one cycle, in the cycle after an advance event that wrapped the counter to 0.
REQ-019 sq_out[i] SHALL toggle in the same cycle that tick[i] asserts, giving period 2*div advance events with 50 % duty.
REQ-020 load_ready SHALL equal the inverse of pend[load_ch]; when load_valid is low, load_ready still reflects the addressed channel.
REQ-021 An accepted load SHALL set pend and capture pdiv.
REQ-022 A pending divisor SHALL become div, and pend SHALL clear, on the channel's next wrap to 0, or in the next cycle if en[i] is low, or on sync. Counts in progress are never truncated.
REQ-023 sync SHALL, in the next cycle, set every cnt to 0 and every sq_out to 0, hold tick at 0, and apply any pending divisors. sync SHALL take priority over advance events in the same cycle.
REQ-024 When en[i] is low, cnt[i] and sq_out[i] SHALL hold their values and tick[i] SHALL be 0.
REQ-025 A load accepted in the same cycle as that channel's wrap SHALL become pending and apply at the following wrap.

Reset
REQ-026 Step condition: without TICK_DIVIDER_CASCADE_EN it SHALL be every clock cycle; with the macro, see REQ-030.
REQ-027 While rst is high at a rising clock edge, every cnt SHALL become 0, div SHALL become DIV_INIT, pend SHALL become 0, and tick and sq_out SHALL become 0; load_ready SHALL then read 1.
REQ-028 rst SHALL override sync, load and en, and asserting rst mid-count SHALL discard any pending loads.
REQ-029 The first tick[0] with DIV_INIT=D, en[0] held high, SHALL appear D+1 edges after the first edge with rst low.

Configuration
REQ-030 With TICK_DIVIDER_CASCADE_EN defined, the step condition for channel 0 SHALL be every cycle, and for channel i>0 SHALL be tick[i-1]=1 (one cycle of added latency per stage).
REQ-031 Without TICK_DIVIDER_CASCADE_EN, all channels SHALL count clk_50Mhz independently; interface and reset behaviour SHALL be identical in both builds.

Structure
REQ-032 Package tick_div_pkg SHALL hold the default constants (DIV_INIT, maximum NUM_CH) and a channel-state struct type (cnt, div, pdiv, pend).
REQ-033 Per-channel logic SHALL be a sub-module tick_div_chan, instantiated NUM_CH times by a generate loop. The top level SHALL hold load decode, load_ready and cascade wiring.

Verification
REQ-034 Scenario: NUM_CH=2, DIV_INIT=4, en=11, reset then release -> tick[0] on edges 5, 9, 13; sq_out[0] toggles at each tick; period 8 cycles.
REQ-035 Scenario: mid-count (cnt=1) load ch0 div=2 -> load_ready low until the next wrap; subsequent ticks every 2 cycles; a second load while pending is not accepted.
REQ-036 Scenario: en[0]=0 for 10 cycles at cnt=2 -> no tick, sq_out held; re-enable -> tick 2 advance events later.
REQ-037 Scenario: sync asserted with cnt=3 and sq_out=1 -> next cycle cnt=0, sq_out=0, no tick; next tick 5 edges after sync.
REQ-038 Scenario: cascade build, div0=4, div1=3 -> tick[1] every 12 cycles, trailing tick[0] by 1 cycle; load_div=0 -> tick every advance event.
REQ-039 Scenario: rst pulse mid-count with a pending load -> all outputs 0, div=DIV_INIT, load_ready=1, pending value never applied.
